tt_checker: RTL

- Sequential stimulus/response engine for the 2-input combinational function blocks in the exercise set (the f(a,b) = a + b' family).
- On start, drives minterms m0..m3 onto the function's inputs and waits a settle time.
- Samples the function output for each minterm, builds the observed truth table and compares it against an expected table.
- Sits directly upstream and downstream of the function under test: feeds its a/b inputs and consumes its s output. It replaces the hand-written initial-block stimulus with a synthesizable self-check.

---
 rtl/tt_checker_pkg.sv | 18 +
 rtl/tt_checker_settle.sv | 35 +++
 rtl/tt_checker.sv | 126 ++++++++++++
 3 files changed

// File: rtl/tt_checker_pkg.sv
// Shared types and constants for the 2-input truth-table checker.
// State encoding and reference tables for the exercise functions.
package tt_checker_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } tt_state_e;

  // Bit m holds f(m[1], m[0]).
  localparam logic [3:0] TtF5   = 4'b1101;
  localparam logic [3:0] TtNand = 4'b0111;

  localparam int unsigned CntW = 4;

endpackage

// File: rtl/tt_checker_settle.sv
// Settle-time counter: clear/enable with a terminal-count flag at SETTLE-1.
module tt_checker_settle
  import tt_checker_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CntW'(SETTLE - 1));

endmodule

// File: rtl/tt_checker.sv
// Drives minterms m0..m3 into a 2-input function, samples its output after a
// settle delay and compares the observed truth table against EXPECTED.
module tt_checker
  import tt_checker_pkg::*;
#(
  parameter int unsigned SETTLE   = 2,
  parameter logic [3:0]  EXPECTED = TtF5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_s,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] tt,
  output logic [2:0] err_count,
  output logic [1:0] fail_idx
);

  tt_state_e  state_q;
  logic [1:0] m_q;
  logic       a_q, b_q, busy_q, done_q, pass_q;
  logic [3:0] tt_q;
  logic [2:0] err_q;
  logic [1:0] fail_idx_q;

  logic       start_acc;
  logic       timer_clr, timer_en, timer_tc;
  logic       mismatch;
  logic [2:0] err_next;

  always_comb begin
    start_acc = start && !abort && ((state_q == StIdle) || (state_q == StDone));
    timer_clr = start_acc || ((state_q == StSample) && !abort);
    timer_en  = (state_q == StWait) && !abort;
    mismatch  = (dut_s != EXPECTED[m_q]);
    err_next  = err_q + {2'b00, mismatch};
  end

  tt_checker_settle #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (timer_clr),
    .en_i   (timer_en),
    .tc_o   (timer_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      m_q        <= 2'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tt_q       <= 4'd0;
      err_q      <= 3'd0;
      fail_idx_q <= 2'd0;
    end else if (abort) begin
      // Partial tt/err_count stay visible for debug.
      state_q <= StIdle;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StWait;
            m_q        <= 2'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            tt_q       <= 4'd0;
            err_q      <= 3'd0;
            fail_idx_q <= 2'd0;
          end
        end
        StWait: begin
          if (timer_tc) begin
            state_q <= StSample;
          end
        end
        StSample: begin
          tt_q[m_q] <= dut_s;
          err_q     <= err_next;
          if (mismatch && (err_q == 3'd0)) begin
            fail_idx_q <= m_q;
          end
          if (m_q == 2'd3) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_next == 3'd0);
          end else begin
            state_q    <= StWait;
            m_q        <= m_q + 2'd1;
            {a_q, b_q} <= m_q + 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign tt        = tt_q;
  assign err_count = err_q;
  assign fail_idx  = fail_idx_q;

endmodule
